// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side consumer for a synchronous FIFO with a registered read port
// (one-cycle read latency). It issues FIFO reads, absorbs the read latency
// in a two-entry skid buffer and presents the words as a valid/ready stream.
// With m_ready held high it sustains one word per cycle, and no word is lost
// or duplicated under any pattern of backpressure.
//
// Ports
//   clk         in   1           single clock, rising edge
//   rst_n       in   1           asynchronous, active-low reset
//   flush       in   1           synchronous clear of buffer and in-flight read
//   fifo_empty  in   1           FIFO empty flag
//   fifo_rd_en  out  1           FIFO read request (combinational)
//   fifo_dout   in   DATA_WIDTH  FIFO read data, valid the cycle after a read
//   m_valid     out  1           stream data valid
//   m_ready     in   1           stream consumer ready
//   m_data      out  DATA_WIDTH  stream data (oldest buffered word)
//   buf_cnt     out  2           words held in the skid buffer (0..2)
//   beat_cnt    out  CNT_WIDTH   delivered-beat counter, wraps
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            buf_cnt,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    localparam logic [CNT_WIDTH-1:0] BEAT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  beat_q, beat_d;

    logic       pop;
    logic       capture;
    logic [2:0] occupancy;
    logic [1:0] wr_idx;

    // A beat presented during flush is dropped, so it is neither a pop nor
    // counted; likewise a word returning from the FIFO during flush is discarded.
    assign m_valid = (cnt_q != 2'd0);
    assign pop     = m_valid & m_ready & ~flush;
    assign capture = inflight_q & ~flush;

    // Space left after this cycle's pop must also cover the read already in
    // flight; this keeps cnt + inflight <= 2, so the buffer cannot overflow.
    // The m_ready -> fifo_rd_en path through pop is deliberate and is what
    // allows full throughput with a two-entry buffer.
    assign occupancy  = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = rst_n & ~fifo_empty & ~flush & (occupancy < 3'd2);

    // The returning word lands behind anything leaving the buffer this cycle.
    assign wr_idx = cnt_q - {1'b0, pop};

    assign m_data   = head_q;
    assign buf_cnt  = cnt_q;
    assign beat_cnt = beat_q;

    // Next-state logic: shift on pop, then place the captured word, then
    // update the occupancy and the beat counter.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        inflight_d = inflight_q;
        beat_d     = beat_q;

        if (flush) begin
            cnt_d      = 2'd0;
            inflight_d = 1'b0;
        end else begin
            inflight_d = fifo_rd_en;

            if (pop) begin
                head_d = tail_q;
                beat_d = beat_q + BEAT_ONE;
            end

            if (capture) begin
                if (wr_idx == 2'd0) begin
                    head_d = fifo_dout;
                end else begin
                    tail_d = fifo_dout;
                end
            end

            cnt_d = cnt_q + {1'b0, capture} - {1'b0, pop};
        end
    end

    // State registers; reset clears the buffer, the in-flight read and the
    // beat counter immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            beat_q     <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Self-checking bench for fifo_stream_reader. A behavioural FIFO with a
// one-cycle registered read feeds the reader; every word written into it is
// also pushed onto an expected-data queue, and a monitor pops that queue
// whenever a beat is accepted downstream. A second instance with a 4-bit
// beat counter shares the same inputs to exercise counter wrap.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int DW = 8;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          flush      = 1'b0;
    logic          m_ready    = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout  = '0;

    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [1:0]    buf_cnt;
    logic [15:0]   beat_cnt;

    logic          rd_en4;
    logic          m_valid4;
    logic [DW-1:0] m_data4;
    logic [1:0]    buf_cnt4;
    logic [3:0]    beat_cnt4;

    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] expQ[$];

    int checks   = 0;
    int passed   = 0;
    int rdPulses = 0;

    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .buf_cnt(buf_cnt), .beat_cnt(beat_cnt)
    );

    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_rd_en(rd_en4), .fifo_dout(fifo_dout),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
        .buf_cnt(buf_cnt4), .beat_cnt(beat_cnt4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] w);
        fifoQ.push_back(w);
        expQ.push_back(w);
    endtask

    task automatic resetDut();
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        step(2);
        fifoQ.delete();
        expQ.delete();
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic drainWait(input string name, input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        checkOutput(name, expQ.size(), 0);
    endtask

    // Behavioural sync FIFO: registered read data, empty flag updated at the edge.
    always @(posedge clk) begin
        if (fifo_rd_en && fifoQ.size() > 0) begin
            fifo_dout <= fifoQ.pop_front();
        end
        fifo_empty <= (fifoQ.size() == 0);
    end

    // Monitor: invariants every cycle, scoreboard compare on each accepted beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd_en) begin
                rdPulses++;
            end
            checkOutput("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 0);
            checkOutput("cnt_plus_inflight_le_2",
                        32'((int'(u_dut.cnt_q) + int'(u_dut.inflight_q)) <= 2), 1);
            if (m_valid && m_ready && !flush) begin
                checkOutput("beat_expected", 32'(expQ.size() != 0), 1);
                if (expQ.size() != 0) begin
                    checkOutput("stream_data", 32'(m_data), 32'(expQ.pop_front()));
                end
            end
        end
    end

    initial begin
        logic          rdS[10];
        logic          vS[10];
        logic [DW-1:0] dS[10];
        int            f;
        int            r0;
        int            pushed;
        int            cyc;

        // T1: held in reset, then idle with an empty FIFO.
        $display("[TB] T1 reset and idle");
        rst_n   = 1'b0;
        m_ready = 1'b1;
        step(10);
        checkOutput("t1_rst_rd_en", 32'(fifo_rd_en), 0);
        checkOutput("t1_rst_m_valid", 32'(m_valid), 0);
        checkOutput("t1_rst_m_data", 32'(m_data), 0);
        checkOutput("t1_rst_buf_cnt", 32'(buf_cnt), 0);
        checkOutput("t1_rst_beat_cnt", 32'(beat_cnt), 0);
        rst_n = 1'b1;
        step(10);
        checkOutput("t1_idle_rd_en", 32'(fifo_rd_en), 0);
        checkOutput("t1_idle_m_valid", 32'(m_valid), 0);
        checkOutput("t1_idle_buf_cnt", 32'(buf_cnt), 0);
        checkOutput("t1_idle_beat_cnt", 32'(beat_cnt), 0);

        // T2: three words, back-to-back reads, delivered two cycles later.
        $display("[TB] T2 three-word burst latency");
        resetDut();
        m_ready = 1'b1;
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        for (int i = 0; i < 10; i++) begin
            step(1);
            rdS[i] = fifo_rd_en;
            vS[i]  = m_valid;
            dS[i]  = m_data;
        end
        f = -1;
        for (int i = 9; i >= 0; i--) begin
            if (rdS[i]) f = i;
        end
        checkOutput("t2_rd_seen", 32'(f >= 0 && f <= 4), 1);
        if (f < 0 || f > 4) f = 0;
        checkOutput("t2_rd0", 32'(rdS[f]), 1);
        checkOutput("t2_rd1", 32'(rdS[f+1]), 1);
        checkOutput("t2_rd2", 32'(rdS[f+2]), 1);
        checkOutput("t2_rd3", 32'(rdS[f+3]), 0);
        checkOutput("t2_valid_early", 32'(vS[f+1]), 0);
        checkOutput("t2_valid0", 32'(vS[f+2]), 1);
        checkOutput("t2_data0", 32'(dS[f+2]), 32'h11);
        checkOutput("t2_valid1", 32'(vS[f+3]), 1);
        checkOutput("t2_data1", 32'(dS[f+3]), 32'h22);
        checkOutput("t2_valid2", 32'(vS[f+4]), 1);
        checkOutput("t2_data2", 32'(dS[f+4]), 32'h33);
        checkOutput("t2_valid_end", 32'(vS[f+5]), 0);
        checkOutput("t2_beat_cnt", 32'(beat_cnt), 3);

        // T3: full backpressure stops after two reads, then full-rate drain.
        $display("[TB] T3 backpressure then drain");
        resetDut();
        r0 = rdPulses;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(8'hA0 + i));
        end
        step(10);
        checkOutput("t3_rd_pulses", 32'(rdPulses - r0), 2);
        checkOutput("t3_buf_cnt", 32'(buf_cnt), 2);
        checkOutput("t3_m_valid_held", 32'(m_valid), 1);
        checkOutput("t3_m_data_held", 32'(m_data), 32'hA0);
        m_ready = 1'b1;
        step(16);
        checkOutput("t3_no_gaps", expQ.size(), 0);
        checkOutput("t3_beat_cnt", 32'(beat_cnt), 16);
        checkOutput("t3_valid_after", 32'(m_valid), 0);

        // T4: random backpressure over 1000 random words.
        $display("[TB] T4 random backpressure");
        resetDut();
        pushed = 0;
        cyc    = 0;
        while ((pushed < 1000 || expQ.size() != 0) && cyc < 20000) begin
            if (pushed < 1000 && fifoQ.size() < 8) begin
                applyStimulus(8'($urandom_range(0, 255)));
                pushed++;
            end
            m_ready = 1'($urandom_range(0, 1));
            step(1);
            cyc++;
        end
        checkOutput("t4_drained", expQ.size(), 0);
        checkOutput("t4_beat_cnt", 32'(beat_cnt), 1000);

        // T5: flush with one buffered word and one read in flight.
        $display("[TB] T5 flush");
        resetDut();
        applyStimulus(8'h5A);
        step(2);
        applyStimulus(8'hA5);
        applyStimulus(8'hC3);
        step(2);
        checkOutput("t5_pre_buf_cnt", 32'(buf_cnt), 1);
        checkOutput("t5_pre_inflight", 32'(u_dut.inflight_q), 1);
        flush = 1'b1;
        #1;
        checkOutput("t5_flush_rd_en", 32'(fifo_rd_en), 0);
        step(1);
        checkOutput("t5_post_m_valid", 32'(m_valid), 0);
        checkOutput("t5_post_buf_cnt", 32'(buf_cnt), 0);
        flush = 1'b0;
        void'(expQ.pop_front());
        void'(expQ.pop_front());
        m_ready = 1'b1;
        drainWait("t5_next_word", 20);
        checkOutput("t5_beat_cnt", 32'(beat_cnt), 1);

        // T6: 4-bit counter wrap, then asynchronous reset mid-stream.
        $display("[TB] T6 counter wrap and async reset");
        resetDut();
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(8'(8'h40 + i));
        end
        drainWait("t6_drain", 100);
        checkOutput("t6_beat_cnt4_wrap", 32'(beat_cnt4), 1);
        checkOutput("t6_beat_cnt16", 32'(beat_cnt), 17);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'(8'h70 + i));
        end
        step(4);
        checkOutput("t6_midstream_valid", 32'(m_valid), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_m_valid", 32'(m_valid), 0);
        checkOutput("t6_rst_m_data", 32'(m_data), 0);
        checkOutput("t6_rst_beat_cnt", 32'(beat_cnt), 0);
        checkOutput("t6_rst_rd_en", 32'(fifo_rd_en), 0);
        checkOutput("t6_rst_m_valid4", 32'(m_valid4), 0);
        checkOutput("t6_rst_m_data4", 32'(m_data4), 0);
        checkOutput("t6_rst_beat_cnt4", 32'(beat_cnt4), 0);
        checkOutput("t6_rst_buf_cnt4", 32'(buf_cnt4), 0);
        checkOutput("t6_rst_rd_en4", 32'(rd_en4), 0);
        fifoQ.delete();
        expQ.delete();
        step(2);
        rst_n = 1'b1;
        step(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
